uart_frame_loader: RTL and testbench

- Consumes the byte stream produced by the UART receiver: an 8-bit data byte plus a one-cycle done strobe.
- Frames one digit image from the stream as: sync header, IMG_W*IMG_H pixel bytes, then an 8-bit checksum.
- Writes each pixel into the image buffer RAM through a simple write port.
- Holds the buffer locked after a good frame until the classifier acknowledges it.

---
 rtl/uart_frame_pkg.sv | 27 ++
 rtl/uart_frame_loader_gap_timer.sv | 37 +++
 rtl/uart_frame_loader.sv | 174 +++++++++++++++++
 tb/tb_uart_frame_loader.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/uart_frame_pkg.sv
// Shared definitions for the UART frame loader.
// Holds the loader state encoding, default sync header bytes and helpers
// that size the pixel buffer from the image geometry.
package uart_frame_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SYNC,
    ST_PIXELS,
    ST_CHECK,
    ST_HOLD
  } frame_state_e;

  localparam logic [7:0] SYNC0_DEF = 8'hAA;
  localparam logic [7:0] SYNC1_DEF = 8'h55;

  // Number of pixels in one image.
  function automatic int unsigned npix(input int unsigned w, input int unsigned h);
    return w * h;
  endfunction

  // Smallest address width able to hold every pixel of one image.
  function automatic int unsigned min_addr_w(input int unsigned w, input int unsigned h);
    return (w * h > 1) ? $clog2(w * h) : 1;
  endfunction

endpackage

// File: rtl/uart_frame_loader_gap_timer.sv
// Inter-byte gap timer.
// Counts consecutive cycles without a kick while enabled; expire is high in
// the cycle that completes TIMEOUT_CYC idle cycles.
// Ports:
//   clk, reset : clock, asynchronous active-high reset
//   enable     : counting allowed (counter held at 0 when low)
//   kick       : byte arrived this cycle; clears the counter
//   expire     : single-cycle timeout indication
module uart_gap_timer #(
  parameter int unsigned TIMEOUT_CYC = 1000000
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  input  logic kick,
  output logic expire
);

  localparam int unsigned CW = $clog2(TIMEOUT_CYC + 1);

  logic [CW-1:0] gap_q, gap_d;

  always_comb begin
    gap_d = '0;
    if (enable && !kick) gap_d = gap_q + CW'(1);
  end

  // gap_q holds the idle cycles already seen, so the current idle cycle is
  // the terminal one when gap_q reaches TIMEOUT_CYC-1.
  assign expire = enable && !kick && (gap_q == CW'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) gap_q <= '0;
    else       gap_q <= gap_d;
  end

endmodule

// File: rtl/uart_frame_loader.sv
// UART frame loader.
// Frames one image from the UART byte stream (sync header, IMG_W*IMG_H
// pixels, 8-bit additive checksum), writes pixels into the image buffer and
// holds the buffer locked after a good frame until frame_ack.
// Ports:
//   clk, reset            : clock, asynchronous active-high reset
//   rx_data, rx_valid     : received byte and its one-cycle strobe
//   frame_ack             : classifier done with buffer, releases hold
//   wr_en/wr_addr/wr_data : buffer write port
//   frame_busy            : frame reception in progress
//   frame_valid           : buffer holds a complete checked frame
//   frame_done, err_checksum, err_timeout, overrun : one-cycle event pulses
module uart_frame_loader
  import uart_frame_pkg::*;
#(
  parameter int unsigned IMG_W       = 28,
  parameter int unsigned IMG_H       = 28,
  parameter int unsigned ADDR_W      = 10,
  parameter logic [7:0]  SYNC0       = SYNC0_DEF,
  parameter logic [7:0]  SYNC1       = SYNC1_DEF,
  parameter int unsigned TIMEOUT_CYC = 1000000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  input  logic              frame_ack,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [7:0]        wr_data,
  output logic              frame_busy,
  output logic              frame_valid,
  output logic              frame_done,
  output logic              err_checksum,
  output logic              err_timeout,
  output logic              overrun
);

  localparam int unsigned NPIX = npix(IMG_W, IMG_H);

  frame_state_e      state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [7:0]        sum_q, sum_d;
  logic              wr_en_q, wr_en_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [7:0]        wr_data_q, wr_data_d;
  logic              busy_q, busy_d;
  logic              valid_q, valid_d;
  logic              done_q, done_d;
  logic              cks_q, cks_d;
  logic              tmo_q, tmo_d;
  logic              ovr_q, ovr_d;
  logic              receiving;
  logic              expire;

  assign receiving = (state_q == ST_SYNC) || (state_q == ST_PIXELS) || (state_q == ST_CHECK);

  uart_gap_timer #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_gap_timer (
    .clk   (clk),
    .reset (reset),
    .enable(receiving),
    .kick  (rx_valid),
    .expire(expire)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    sum_d     = sum_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    done_d    = 1'b0;
    cks_d     = 1'b0;
    tmo_d     = 1'b0;
    ovr_d     = 1'b0;

    // expire is never asserted with rx_valid, so a byte on the terminal
    // cycle is handled normally below.
    if (expire) begin
      state_d = ST_IDLE;
      tmo_d   = 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (rx_valid && rx_data == SYNC0) state_d = ST_SYNC;
        end
        ST_SYNC: begin
          if (rx_valid) begin
            if (rx_data == SYNC1) begin
              state_d = ST_PIXELS;
              cnt_d   = '0;
              sum_d   = '0;
            end else if (rx_data != SYNC0) begin
              state_d = ST_IDLE;
            end
          end
        end
        ST_PIXELS: begin
          if (rx_valid) begin
            wr_en_d   = 1'b1;
            wr_addr_d = cnt_q;
            wr_data_d = rx_data;
            sum_d     = sum_q + rx_data;
            cnt_d     = cnt_q + ADDR_W'(1);
            if (cnt_q == ADDR_W'(NPIX - 1)) state_d = ST_CHECK;
          end
        end
        ST_CHECK: begin
          if (rx_valid) begin
            if (rx_data == sum_q) begin
              state_d = ST_HOLD;
              done_d  = 1'b1;
            end else begin
              state_d = ST_IDLE;
              cks_d   = 1'b1;
            end
          end
        end
        ST_HOLD: begin
          if (frame_ack)     state_d = ST_IDLE;
          else if (rx_valid) ovr_d   = 1'b1;
        end
        default: state_d = ST_IDLE;
      endcase
    end

    busy_d  = (state_d == ST_SYNC) || (state_d == ST_PIXELS) || (state_d == ST_CHECK);
    valid_d = (state_d == ST_HOLD);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      sum_q     <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      busy_q    <= 1'b0;
      valid_q   <= 1'b0;
      done_q    <= 1'b0;
      cks_q     <= 1'b0;
      tmo_q     <= 1'b0;
      ovr_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      sum_q     <= sum_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      busy_q    <= busy_d;
      valid_q   <= valid_d;
      done_q    <= done_d;
      cks_q     <= cks_d;
      tmo_q     <= tmo_d;
      ovr_q     <= ovr_d;
    end
  end

  assign wr_en        = wr_en_q;
  assign wr_addr      = wr_addr_q;
  assign wr_data      = wr_data_q;
  assign frame_busy   = busy_q;
  assign frame_valid  = valid_q;
  assign frame_done   = done_q;
  assign err_checksum = cks_q;
  assign err_timeout  = tmo_q;
  assign overrun      = ovr_q;

endmodule

// File: tb/tb_uart_frame_loader.sv
module tb_uart_frame_loader;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] rx_data = '0;
  logic       rx_valid = 1'b0;
  logic       frame_ack = 1'b0;
  logic       wr_en;
  logic [9:0] wr_addr;
  logic [7:0] wr_data;
  logic       frame_busy, frame_valid, frame_done;
  logic       err_checksum, err_timeout, overrun;

  int n_cmp = 0;
  int n_bad = 0;

  int cyc = 0;
  int n_wr = 0, n_addr_bad = 0, exp_addr = 0;
  int n_done = 0, n_cks = 0, n_to = 0, n_ovr = 0;
  int last_wr_cyc = 0, to_cyc = 0;

  uart_frame_loader #(
    .IMG_W      (28),
    .IMG_H      (28),
    .ADDR_W     (10),
    .SYNC0      (8'hAA),
    .SYNC1      (8'h55),
    .TIMEOUT_CYC(1000)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .frame_ack   (frame_ack),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .frame_busy  (frame_busy),
    .frame_valid (frame_valid),
    .frame_done  (frame_done),
    .err_checksum(err_checksum),
    .err_timeout (err_timeout),
    .overrun     (overrun)
  );

  always #5 clk = ~clk;

  // Event monitor: sampled on the falling edge, away from the active edge.
  always @(negedge clk) begin
    cyc++;
    if (wr_en) begin
      n_wr++;
      if (wr_addr !== 10'(exp_addr) || wr_data !== 8'(exp_addr)) n_addr_bad++;
      exp_addr++;
      last_wr_cyc = cyc;
    end
    if (frame_done)   n_done++;
    if (err_checksum) n_cks++;
    if (overrun)      n_ovr++;
    if (err_timeout) begin
      n_to++;
      to_cyc = cyc;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clr_counts();
    #1;
    n_wr = 0; n_addr_bad = 0; exp_addr = 0;
    n_done = 0; n_cks = 0; n_to = 0; n_ovr = 0;
  endtask

  task automatic settle();
    @(negedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic send_pixels(input int n);
    for (int i = 0; i < n; i++) send_byte(8'(i));
  endtask

  task automatic send_frame(input logic [7:0] cks);
    send_byte(8'hAA);
    send_byte(8'h55);
    send_pixels(784);
    send_byte(cks);
  endtask

  task automatic pulse_ack();
    @(negedge clk);
    frame_ack = 1'b1;
    @(negedge clk);
    frame_ack = 1'b0;
  endtask

  task automatic check_good(input string tag);
    settle();
    check_eq({tag, "_nwr"}, n_wr, 784);
    check_eq({tag, "_addr"}, n_addr_bad, 0);
    check_eq({tag, "_done"}, n_done, 1);
    check_eq({tag, "_valid"}, frame_valid, 1);
  endtask

  logic [25:0] outs;
  assign outs = {wr_en, wr_addr, wr_data, frame_busy, frame_valid, frame_done,
                 err_checksum, err_timeout, overrun};

  initial begin
    repeat (3) @(negedge clk);
    check_eq("reset_outs", outs, 0);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("idle_outs", outs, 0);

    // Good frame; done pulse one cycle after the checksum strobe.
    clr_counts();
    send_byte(8'hAA);
    send_byte(8'h55);
    send_pixels(784);
    check_eq("busy_in_check", frame_busy, 1);
    send_byte(8'hF8);
    check_eq("done_latency", frame_done, 1);
    check_good("good");
    repeat (20) @(negedge clk);
    check_eq("valid_stays", frame_valid, 1);

    // Overrun while holding, then ack.
    clr_counts();
    for (int i = 0; i < 3; i++) send_byte(8'h11);
    settle();
    check_eq("ovr_count", n_ovr, 3);
    check_eq("ovr_no_wr", n_wr, 0);
    pulse_ack();
    check_eq("ack_valid_low", frame_valid, 0);

    // Bad checksum.
    clr_counts();
    send_frame(8'hF9);
    settle();
    check_eq("bad_cks", n_cks, 1);
    check_eq("bad_done", n_done, 0);
    check_eq("bad_valid", frame_valid, 0);
    check_eq("bad_busy", frame_busy, 0);

    // Sync hunting: junk and repeated SYNC0 before the header.
    clr_counts();
    send_byte(8'h12);
    send_byte(8'hAA);
    send_frame(8'hF8);
    check_good("hunt");

    // Ack and byte together: ack wins, no overrun.
    clr_counts();
    @(negedge clk);
    frame_ack = 1'b1;
    rx_data   = 8'h33;
    rx_valid  = 1'b1;
    @(negedge clk);
    frame_ack = 1'b0;
    rx_valid  = 1'b0;
    check_eq("ackrx_ovr", overrun, 0);
    check_eq("ackrx_valid", frame_valid, 0);

    // Broken header: no writes at all.
    clr_counts();
    send_byte(8'hAA);
    send_byte(8'h00);
    send_byte(8'h55);
    send_pixels(784);
    settle();
    check_eq("badsync_nwr", n_wr, 0);
    check_eq("badsync_busy", frame_busy, 0);

    // Timeout after 100 pixels.
    clr_counts();
    send_byte(8'hAA);
    send_byte(8'h55);
    send_pixels(100);
    check_eq("to_busy", frame_busy, 1);
    for (int i = 0; i < 1100 && n_to == 0; i++) @(negedge clk);
    #1;
    check_eq("to_seen", n_to, 1);
    check_eq("to_delay", to_cyc - last_wr_cyc, 1000);
    repeat (5) @(negedge clk);
    #1;
    check_eq("to_nwr", n_wr, 100);
    check_eq("to_busy_low", frame_busy, 0);
    clr_counts();
    send_frame(8'hF8);
    check_good("after_to");
    pulse_ack();

    // Reset in the middle of a frame.
    clr_counts();
    send_byte(8'hAA);
    send_byte(8'h55);
    send_pixels(401);
    check_eq("mid_wr_before", wr_en, 1);
    reset = 1'b1;
    #1;
    check_eq("mid_reset_outs", outs, 0);
    repeat (2) @(negedge clk);
    check_eq("mid_reset_hold", outs, 0);
    reset = 1'b0;
    clr_counts();
    send_frame(8'hF8);
    check_good("after_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
